// File: rtl/vga_clock_pkg.sv
// Shared sizes for the VGA clock glyph path, so the block-coordinate
// generator and the font lookup agree on cell geometry and field widths.
package vga_clock_pkg;

    localparam int unsigned GLYPH_W    = 4;
    localparam int unsigned GLYPH_H    = 5;
    localparam int unsigned CODE_W     = 4;
    localparam int unsigned COORD_W    = 6;
    localparam int unsigned ROW_W      = 3;

    localparam logic [CODE_W-1:0] CODE_COLON = 4'd10;

    typedef logic [CODE_W-1:0]  glyph_code_t;
    typedef logic [COORD_W-1:0] block_coord_t;
    typedef logic [ROW_W-1:0]   glyph_row_t;
    typedef logic [GLYPH_W-1:0] glyph_bits_t;

endpackage

// File: rtl/digit_font_rom.sv
// Combinational 5x4 font for digits 0-9 and the colon; bit 3 of each row is
// the leftmost column. Unused codes and rows beyond the cell read as blank.
module digit_font_rom
    import vga_clock_pkg::*;
(
    input  glyph_code_t number,
    input  glyph_row_t  row,
    output glyph_bits_t bits
);

    // Five hex rows per code, top row in the most significant nibble.
    logic [4*GLYPH_H-1:0] glyph;

    always_comb begin
        glyph = '0;
        case (number)
            4'd0:       glyph = 20'hEAAAE;
            4'd1:       glyph = 20'h4C44E;
            4'd2:       glyph = 20'hE2E8E;
            4'd3:       glyph = 20'hE2E2E;
            4'd4:       glyph = 20'hAAE22;
            4'd5:       glyph = 20'hE8E2E;
            4'd6:       glyph = 20'hE8EAE;
            4'd7:       glyph = 20'hE2222;
            4'd8:       glyph = 20'hEAEAE;
            4'd9:       glyph = 20'hEAE2E;
            CODE_COLON: glyph = 20'h04040;
            default:    glyph = '0;
        endcase
    end

    always_comb begin
        bits = '0;
        case (row)
            3'd0:    bits = glyph[19:16];
            3'd1:    bits = glyph[15:12];
            3'd2:    bits = glyph[11:8];
            3'd3:    bits = glyph[7:4];
            3'd4:    bits = glyph[3:0];
            default: bits = '0;
        endcase
    end

endmodule

// File: rtl/digit_glyph.sv
// Glyph block lookup: range-checks the block coordinate, selects one column
// of the font row and registers the lit flag with one cycle of latency.
module digit_glyph
    import vga_clock_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CODE_W-1:0]   number,
    input  logic [COORD_W-1:0]  x_block,
    input  logic [COORD_W-1:0]  y_block,
    output logic                pixel,
    output logic                in_cell
);

    glyph_bits_t row_bits;
    logic        in_range;
    logic        lit;
    logic [1:0]  col;

    assign in_range = (x_block < COORD_W'(GLYPH_W)) && (y_block < COORD_W'(GLYPH_H));

    // Low coordinate bits only address the ROM; in_range masks any aliasing.
    digit_font_rom u_rom (
        .number (number),
        .row    (y_block[ROW_W-1:0]),
        .bits   (row_bits)
    );

    always_comb begin
        col = 2'd3 - x_block[1:0];
        lit = in_range & row_bits[col];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel   <= 1'b0;
            in_cell <= 1'b0;
        end else begin
            pixel   <= lit;
            in_cell <= in_range;
        end
    end

endmodule

// File: tb/tb_digit_glyph.sv
// Bench for digit_glyph: directed literal checks plus randomized traffic
// compared every cycle against a table-driven font model.
module tb_digit_glyph;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] number = 4'd8;
    logic [5:0] x_block = '0;
    logic [5:0] y_block = '0;
    logic       pixel;
    logic       in_cell;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    digit_glyph dut (
        .clk     (clk),
        .reset_n (reset_n),
        .number  (number),
        .x_block (x_block),
        .y_block (y_block),
        .pixel   (pixel),
        .in_cell (in_cell)
    );

    always #5 clk = ~clk;

    // Font rows as plain integers, leftmost column has weight 8.
    int font [16][5] = '{
        '{14, 10, 10, 10, 14}, '{ 4, 12,  4,  4, 14}, '{14,  2, 14,  8, 14},
        '{14,  2, 14,  2, 14}, '{10, 10, 14,  2,  2}, '{14,  8, 14,  2, 14},
        '{14,  8, 14, 10, 14}, '{14,  2,  2,  2,  2}, '{14, 10, 14, 10, 14},
        '{14, 10, 14,  2, 14}, '{ 0,  4,  0,  4,  0}, '{ 0,  0,  0,  0,  0},
        '{ 0,  0,  0,  0,  0}, '{ 0,  0,  0,  0,  0}, '{ 0,  0,  0,  0,  0},
        '{ 0,  0,  0,  0,  0}
    };

    function automatic bit model_in_cell(int x, int y);
        return (x < 4) && (y < 5);
    endfunction

    function automatic bit model_pixel(int n, int x, int y);
        if (!model_in_cell(x, y)) return 1'b0;
        return ((font[n][y] / (2 ** (3 - x))) % 2) == 1;
    endfunction

    logic exp_pixel, exp_in_cell;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_pixel   <= 1'b0;
            exp_in_cell <= 1'b0;
        end else begin
            exp_pixel   <= model_pixel(int'(number), int'(x_block), int'(y_block));
            exp_in_cell <= model_in_cell(int'(x_block), int'(y_block));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (pixel !== exp_pixel || in_cell !== exp_in_cell) begin
                miscompares++;
                $display("FAIL model_cmp n=%0d x=%0d y=%0d: got pixel=%b in_cell=%b, want %b %b",
                         number, x_block, y_block, pixel, in_cell, exp_pixel, exp_in_cell);
            end
        end
    end

    task automatic check_now(string name, logic ep, logic ec);
        vectors++;
        if (pixel !== ep || in_cell !== ec) begin
            miscompares++;
            $display("FAIL %s: got pixel=%b in_cell=%b, want %b %b", name, pixel, in_cell, ep, ec);
        end
    endtask

    // Inputs are applied just after an edge; the result is checked just after the next.
    task automatic drive_chk(int n, int x, int y, logic ep, logic ec, string name);
        number  = 4'(n);
        x_block = 6'(x);
        y_block = 6'(y);
        @(posedge clk);
        #1;
        check_now(name, ep, ec);
    endtask

    initial begin
        logic [10:0] sweep_exp;
        logic [4:0]  ysweep_exp;
        sweep_exp  = 11'b01101111110;   // codes 10..0 at x=1,y=2 (code 0 in LSB)
        ysweep_exp = 5'b10001;          // rows 4..0 of code 0 at x=1

        repeat (3) @(posedge clk);
        #1;
        check_now("reset_hold", 1'b0, 1'b0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        drive_chk(8, 0, 0, 1'b1, 1'b1, "reset_release");

        for (int n = 0; n <= 10; n++) begin
            drive_chk(n, 1, 2, sweep_exp[n], 1'b1, "num_sweep");
            drive_chk(n, 1, 2, sweep_exp[n], 1'b1, "num_sweep_hold");
        end

        for (int x = 0; x <= 22; x++)
            drive_chk(0, x, 0, (x <= 2), (x <= 3), "x_sweep");

        for (int y = 0; y <= 4; y++)
            drive_chk(0, 1, y, ysweep_exp[y], 1'b1, "y_sweep");
        drive_chk(0, 1, 5, 1'b0, 1'b0, "y_out");
        drive_chk(8, 63, 63, 1'b0, 1'b0, "corner_out");
        drive_chk(8, 4, 0, 1'b0, 1'b0, "alias_x4");
        drive_chk(8, 0, 8, 1'b0, 1'b0, "alias_y8");

        for (int y = 0; y <= 5; y++)
            for (int x = 0; x <= 4; x++)
                drive_chk(10, x, y, (x == 1) && (y == 1 || y == 3), (x < 4) && (y < 5), "colon");

        for (int n = 11; n <= 15; n++)
            for (int y = 0; y <= 4; y++)
                for (int x = 0; x <= 3; x++)
                    drive_chk(n, x, y, 1'b0, 1'b1, "blank_code");

        drive_chk(1, 0, 4, 1'b1, 1'b1, "b2b_1");
        drive_chk(7, 0, 4, 1'b0, 1'b1, "b2b_7");
        drive_chk(8, 0, 4, 1'b1, 1'b1, "b2b_8");

        // Asynchronous reset in mid-stream must clear outputs before any edge.
        #3 reset_n = 1'b0;
        #1 check_now("mid_reset", 1'b0, 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        drive_chk(8, 2, 4, 1'b1, 1'b1, "mid_reset_release");

        for (int i = 0; i < 3000; i++) begin
            number = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) begin
                x_block = 6'($urandom_range(0, 5));
                y_block = 6'($urandom_range(0, 6));
            end else begin
                x_block = 6'($urandom_range(0, 63));
                y_block = 6'($urandom_range(0, 63));
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
